n2_btb_upd_ctrl: RTL and testbench

N2_BTB_UPD_CTRL -- requirements
Module: n2_btb_upd_ctrl

---
 rtl/n2_btb_upd_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_n2_btb_upd_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n2_btb_upd_ctrl.sv
// Main-BTB update controller: clears both banks after reset, then drains a small
// queue of EX/D2 branch updates into the even/odd (pc[2]) banks, two per cycle when they split.
package n2_btb_pkg;
   typedef struct packed {
      logic        valid;
      logic        is_jarl;
      logic [15:0] pc;
      logic [15:0] tgt;
   } btb_t;
endpackage

module n2_btb_upd_ctrl
   import n2_btb_pkg::*;
#(
   parameter int NUM_mBTB = 512,
   parameter int DEPTH_Q  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       btb_upd_v_ex_i,
   input  btb_t                       btb_upd_ex_i,
   input  logic                       btb_upd_v_d2_i,
   input  btb_t                       btb_upd_d2_i,
   output logic                       wren_bank0_o,
   output logic                       wren_bank1_o,
   output logic [8:0]                 addr_bank0_o,
   output logic [8:0]                 addr_bank1_o,
   output logic [33:0]                wdata_bank0_o,
   output logic [33:0]                wdata_bank1_o,
   output logic                       init_done_o,
   output logic [$clog2(DEPTH_Q):0]   q_level_o,
   output logic [7:0]                 drop_cnt_o
);

   localparam int PW = $clog2(DEPTH_Q);
   localparam int LW = PW + 1;

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t          state_q, state_d;
   logic [8:0]      sweep_q, sweep_d;
   btb_t            q_q [DEPTH_Q];
   btb_t            q_d [DEPTH_Q];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic [7:0]      drop_q, drop_d;
   logic            init_done_q, init_done_d;
   logic            wren0_q, wren0_d, wren1_q, wren1_d;
   logic [8:0]      addr0_q, addr0_d, addr1_q, addr1_d;
   btb_t            wdata0_q, wdata0_d, wdata1_q, wdata1_d;

   logic [LW-1:0]   free;
   logic            coalesce, d2_want, acc_ex, acc_d2, pop0, pop1;
   logic [1:0]      n_enq, n_pop, n_drop;
   logic [PW-1:0]   wr_nxt, rd_nxt;
   logic [8:0]      drop_sum;
   btb_t            head, nxt;

   always_comb begin
      state_d     = state_q;
      sweep_d     = sweep_q;
      q_d         = q_q;
      wren0_d     = 1'b0;
      wren1_d     = 1'b0;
      addr0_d     = addr0_q;
      addr1_d     = addr1_q;
      wdata0_d    = wdata0_q;
      wdata1_d    = wdata1_q;
      init_done_d = (state_q == S_READY);

      // Space is judged from the level at the start of the cycle; pops never free room early.
      free     = LW'(DEPTH_Q) - level_q;
      coalesce = btb_upd_v_ex_i && btb_upd_v_d2_i && (btb_upd_ex_i.pc == btb_upd_d2_i.pc);
      d2_want  = btb_upd_v_d2_i && !coalesce;
      acc_ex   = btb_upd_v_ex_i && (free != '0);
      acc_d2   = d2_want && (acc_ex ? (free >= LW'(2)) : (free != '0));
      n_enq    = {1'b0, acc_ex} + {1'b0, acc_d2};
      n_drop   = {1'b0, btb_upd_v_ex_i && !acc_ex} + {1'b0, d2_want && !acc_d2};

      wr_nxt = wr_ptr_q + PW'(1);
      if (acc_ex) q_d[wr_ptr_q] = btb_upd_ex_i;
      if (acc_d2) q_d[acc_ex ? wr_nxt : wr_ptr_q] = btb_upd_d2_i;

      rd_nxt = rd_ptr_q + PW'(1);
      head   = q_q[rd_ptr_q];
      nxt    = q_q[rd_nxt];
      pop0   = (state_q == S_READY) && (level_q != '0);
      pop1   = pop0 && (level_q >= LW'(2)) && (nxt.pc[2] != head.pc[2]);
      n_pop  = {1'b0, pop0} + {1'b0, pop1};

      case (state_q)
         S_INIT: begin
            wren0_d  = 1'b1;
            wren1_d  = 1'b1;
            addr0_d  = sweep_q;
            addr1_d  = sweep_q;
            wdata0_d = '0;
            wdata1_d = '0;
            sweep_d  = sweep_q + 9'd1;
            if (sweep_q == 9'(NUM_mBTB - 1)) state_d = S_READY;
         end
         default: begin
            // The second pop always lands in the bank the head did not use.
            if (pop0) begin
               if (head.pc[2]) begin
                  wren1_d  = 1'b1;
                  addr1_d  = head.pc[11:3];
                  wdata1_d = head;
               end else begin
                  wren0_d  = 1'b1;
                  addr0_d  = head.pc[11:3];
                  wdata0_d = head;
               end
            end
            if (pop1) begin
               if (nxt.pc[2]) begin
                  wren1_d  = 1'b1;
                  addr1_d  = nxt.pc[11:3];
                  wdata1_d = nxt;
               end else begin
                  wren0_d  = 1'b1;
                  addr0_d  = nxt.pc[11:3];
                  wdata0_d = nxt;
               end
            end
         end
      endcase

      wr_ptr_d = wr_ptr_q + PW'(n_enq);
      rd_ptr_d = rd_ptr_q + PW'(n_pop);
      level_d  = level_q + LW'(n_enq) - LW'(n_pop);
      drop_sum = {1'b0, drop_q} + 9'(n_drop);
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_INIT;
         sweep_q     <= '0;
         for (int i = 0; i < DEPTH_Q; i++) q_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         drop_q      <= '0;
         init_done_q <= 1'b0;
         wren0_q     <= 1'b0;
         wren1_q     <= 1'b0;
         addr0_q     <= '0;
         addr1_q     <= '0;
         wdata0_q    <= '0;
         wdata1_q    <= '0;
      end else begin
         state_q     <= state_d;
         sweep_q     <= sweep_d;
         q_q         <= q_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         drop_q      <= drop_d;
         init_done_q <= init_done_d;
         wren0_q     <= wren0_d;
         wren1_q     <= wren1_d;
         addr0_q     <= addr0_d;
         addr1_q     <= addr1_d;
         wdata0_q    <= wdata0_d;
         wdata1_q    <= wdata1_d;
      end
   end

   assign wren_bank0_o  = wren0_q;
   assign wren_bank1_o  = wren1_q;
   assign addr_bank0_o  = addr0_q;
   assign addr_bank1_o  = addr1_q;
   assign wdata_bank0_o = wdata0_q;
   assign wdata_bank1_o = wdata1_q;
   assign init_done_o   = init_done_q;
   assign q_level_o     = level_q;
   assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_n2_btb_upd_ctrl.sv
// Directed bench for n2_btb_upd_ctrl: clear sweep, bank steering, coalescing, overflow, reset.
module tb_n2_btb_upd_ctrl;
   import n2_btb_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ex_v = 1'b0, d2_v = 1'b0;
   btb_t        ex_e = '0, d2_e = '0;
   logic        wren0, wren1, init_done;
   logic [8:0]  addr0, addr1;
   logic [33:0] wdata0, wdata1;
   logic [2:0]  level;
   logic [7:0]  drop;
   int          n_chk = 0, n_pass = 0;

   n2_btb_upd_ctrl #(.NUM_mBTB(512), .DEPTH_Q(4)) dut (
      .clk(clk), .reset(reset),
      .btb_upd_v_ex_i(ex_v), .btb_upd_ex_i(ex_e),
      .btb_upd_v_d2_i(d2_v), .btb_upd_d2_i(d2_e),
      .wren_bank0_o(wren0), .wren_bank1_o(wren1),
      .addr_bank0_o(addr0), .addr_bank1_o(addr1),
      .wdata_bank0_o(wdata0), .wdata_bank1_o(wdata1),
      .init_done_o(init_done), .q_level_o(level), .drop_cnt_o(drop)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ev, input logic [15:0] epc, input logic [15:0] etgt,
                        input logic dv, input logic [15:0] dpc, input logic [15:0] dtgt);
      ex_v = ev;
      ex_e = '{valid: 1'b1, is_jarl: 1'b0, pc: epc, tgt: etgt};
      d2_v = dv;
      d2_e = '{valid: 1'b1, is_jarl: 1'b0, pc: dpc, tgt: dtgt};
   endtask

   task automatic idle();
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic go_ready();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (513) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      #2;
      n_chk++;
      if ({wren0, wren1, addr0, addr1, wdata0, wdata1, init_done, level, drop} !== '0)
         $display("FAIL reset_state: got w%b%b a%h/%h d%h/%h done%b lvl%0d drop%0d, want all 0",
                  wren0, wren1, addr0, addr1, wdata0, wdata1, init_done, level, drop);
      else n_pass++;
   endtask

   task automatic test_init_sweep();
      int bad = 0;
      step();
      reset = 1'b0;
      for (int k = 1; k <= 512; k++) begin
         step();
         n_chk++;
         if (wren0 !== 1'b1 || wren1 !== 1'b1 || addr0 !== 9'(k - 1) || addr1 !== 9'(k - 1) ||
             wdata0 !== 34'h0 || wdata1 !== 34'h0 || init_done !== 1'b0) begin
            if (bad < 5)
               $display("FAIL init_sweep cyc%0d: got w%b%b a%0d/%0d done%b, want w11 a%0d done0",
                        k, wren0, wren1, addr0, addr1, init_done, k - 1);
            bad++;
         end else n_pass++;
      end
      step();
      n_chk++;
      if (init_done !== 1'b1 || wren0 !== 1'b0 || wren1 !== 1'b0)
         $display("FAIL init_done: got done%b w%b%b, want done1 w00", init_done, wren0, wren1);
      else n_pass++;
   endtask

   task automatic test_single();
      go_ready();
      drive(1'b1, 16'h0010, 16'h0100, 1'b0, 16'h0, 16'h0);
      step();
      idle();
      n_chk++;
      if (level !== 3'd1 || wren0 !== 1'b0)
         $display("FAIL single_n1: got lvl%0d w0=%b, want lvl1 w0=0", level, wren0);
      else n_pass++;
      step();
      n_chk++;
      if (wren0 !== 1'b1 || addr0 !== 9'h002 || wdata0 !== {1'b1, 1'b0, 16'h0010, 16'h0100} || wren1 !== 1'b0)
         $display("FAIL single_n2: got w%b%b a%h d%h, want w10 a002 d%h",
                  wren0, wren1, addr0, wdata0, {1'b1, 1'b0, 16'h0010, 16'h0100});
      else n_pass++;
      step();
      n_chk++;
      if (wren0 !== 1'b0 || addr0 !== 9'h002 || level !== 3'd0)
         $display("FAIL single_hold: got w0=%b a%h lvl%0d, want w0=0 a002 lvl0", wren0, addr0, level);
      else n_pass++;
   endtask

   task automatic test_dual_bank();
      go_ready();
      drive(1'b1, 16'h0010, 16'h0200, 1'b1, 16'h0014, 16'h0300);
      step();
      idle();
      step();
      n_chk++;
      if (wren0 !== 1'b1 || wren1 !== 1'b1 || addr0 !== 9'h002 || addr1 !== 9'h002 ||
          wdata0 !== {1'b1, 1'b0, 16'h0010, 16'h0200} || wdata1 !== {1'b1, 1'b0, 16'h0014, 16'h0300})
         $display("FAIL dual_bank: got w%b%b a%h/%h d%h/%h, want w11 a002/002",
                  wren0, wren1, addr0, addr1, wdata0, wdata1);
      else n_pass++;
   endtask

   task automatic test_same_bank();
      go_ready();
      drive(1'b1, 16'h0010, 16'h0400, 1'b1, 16'h0018, 16'h0500);
      step();
      idle();
      step();
      n_chk++;
      if (wren0 !== 1'b1 || addr0 !== 9'h002 || wren1 !== 1'b0 || wdata0 !== {1'b1, 1'b0, 16'h0010, 16'h0400})
         $display("FAIL same_bank_1st: got w%b%b a%h d%h, want w10 a002", wren0, wren1, addr0, wdata0);
      else n_pass++;
      step();
      n_chk++;
      if (wren0 !== 1'b1 || addr0 !== 9'h003 || wren1 !== 1'b0 || wdata0 !== {1'b1, 1'b0, 16'h0018, 16'h0500})
         $display("FAIL same_bank_2nd: got w%b%b a%h d%h, want w10 a003", wren0, wren1, addr0, wdata0);
      else n_pass++;
   endtask

   task automatic test_coalesce();
      go_ready();
      drive(1'b1, 16'h0020, 16'hAAAA, 1'b1, 16'h0020, 16'hBBBB);
      step();
      idle();
      n_chk++;
      if (level !== 3'd1 || drop !== 8'd0)
         $display("FAIL coalesce_q: got lvl%0d drop%0d, want lvl1 drop0", level, drop);
      else n_pass++;
      step();
      n_chk++;
      if (wren0 !== 1'b1 || addr0 !== 9'h004 || wdata0 !== {1'b1, 1'b0, 16'h0020, 16'hAAAA} || wren1 !== 1'b0)
         $display("FAIL coalesce_wr: got w%b%b a%h d%h, want w10 a004 EX data", wren0, wren1, addr0, wdata0);
      else n_pass++;
      step();
      n_chk++;
      if (wren0 !== 1'b0 || drop !== 8'd0)
         $display("FAIL coalesce_once: got w0=%b drop%0d, want w0=0 drop0", wren0, drop);
      else n_pass++;
   endtask

   task automatic test_init_overflow();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive(1'b1, 16'h0100, 16'h1100, 1'b1, 16'h0104, 16'h1104);
      step();
      drive(1'b1, 16'h0108, 16'h1108, 1'b1, 16'h010C, 16'h110C);
      step();
      drive(1'b1, 16'h0110, 16'h1110, 1'b1, 16'h0114, 16'h1114);
      step();
      idle();
      n_chk++;
      if (level !== 3'd4 || drop !== 8'd2)
         $display("FAIL ovf_level: got lvl%0d drop%0d, want lvl4 drop2", level, drop);
      else n_pass++;
      repeat (509) @(posedge clk);
      #1;
      n_chk++;
      if (wren0 !== 1'b1 || addr0 !== 9'd511 || init_done !== 1'b0 || level !== 3'd4)
         $display("FAIL ovf_wait: got w0=%b a%0d done%b lvl%0d, want w0=1 a511 done0 lvl4",
                  wren0, addr0, init_done, level);
      else n_pass++;
      step();
      n_chk++;
      if (wren0 !== 1'b1 || wren1 !== 1'b1 || addr0 !== 9'h020 || addr1 !== 9'h020 ||
          wdata0 !== {1'b1, 1'b0, 16'h0100, 16'h1100} || wdata1 !== {1'b1, 1'b0, 16'h0104, 16'h1104} ||
          level !== 3'd2 || init_done !== 1'b1)
         $display("FAIL ovf_drain1: got w%b%b a%h/%h d%h/%h lvl%0d done%b",
                  wren0, wren1, addr0, addr1, wdata0, wdata1, level, init_done);
      else n_pass++;
      step();
      n_chk++;
      if (wren0 !== 1'b1 || wren1 !== 1'b1 || addr0 !== 9'h021 || addr1 !== 9'h021 ||
          wdata0 !== {1'b1, 1'b0, 16'h0108, 16'h1108} || wdata1 !== {1'b1, 1'b0, 16'h010C, 16'h110C} ||
          level !== 3'd0)
         $display("FAIL ovf_drain2: got w%b%b a%h/%h d%h/%h lvl%0d",
                  wren0, wren1, addr0, addr1, wdata0, wdata1, level);
      else n_pass++;
      step();
      n_chk++;
      if (wren0 !== 1'b0 || wren1 !== 1'b0)
         $display("FAIL ovf_idle: got w%b%b, want w00", wren0, wren1);
      else n_pass++;
   endtask

   task automatic test_drop_saturate();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 130; i++) begin
         drive(1'b1, 16'(i * 8), 16'h0, 1'b1, 16'(i * 8 + 4), 16'h0);
         step();
      end
      idle();
      n_chk++;
      if (drop !== 8'd255 || level !== 3'd4)
         $display("FAIL drop_sat: got drop%0d lvl%0d, want drop255 lvl4", drop, level);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      go_ready();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 16'(16'h0040 + i * 8), 16'(i), 1'b0, 16'h0, 16'h0);
         step();
         if (i >= 1) begin
            n_chk++;
            if (wren0 !== 1'b1 || addr0 !== 9'(8 + i - 1) || wdata0[15:0] !== 16'(i - 1) || level !== 3'd1)
               $display("FAIL b2b_%0d: got w0=%b a%0d tgt%0d lvl%0d, want w0=1 a%0d tgt%0d lvl1",
                        i, wren0, addr0, wdata0[15:0], level, 8 + i - 1, i - 1);
            else n_pass++;
         end
      end
      idle();
      step();
      n_chk++;
      if (wren0 !== 1'b1 || addr0 !== 9'd15 || level !== 3'd0)
         $display("FAIL b2b_last: got w0=%b a%0d lvl%0d, want w0=1 a15 lvl0", wren0, addr0, level);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      go_ready();
      drive(1'b1, 16'h0010, 16'h0, 1'b1, 16'h0018, 16'h0);
      step();
      drive(1'b1, 16'h0020, 16'h0, 1'b1, 16'h0028, 16'h0);
      step();
      idle();
      n_chk++;
      if (level !== 3'd3)
         $display("FAIL rst_mid_fill: got lvl%0d, want 3", level);
      else n_pass++;
      #2;
      reset = 1'b1;
      #1;
      n_chk++;
      if ({wren0, wren1, addr0, addr1, wdata0, wdata1, init_done, level, drop} !== '0)
         $display("FAIL rst_mid_async: got w%b%b a%h/%h done%b lvl%0d drop%0d, want all 0",
                  wren0, wren1, addr0, addr1, init_done, level, drop);
      else n_pass++;
      step();
      reset = 1'b0;
      step();
      n_chk++;
      if (wren0 !== 1'b1 || wren1 !== 1'b1 || addr0 !== 9'd0 || level !== 3'd0 || init_done !== 1'b0)
         $display("FAIL rst_mid_restart: got w%b%b a%0d lvl%0d done%b, want w11 a0 lvl0 done0",
                  wren0, wren1, addr0, level, init_done);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_init_sweep();
      test_single();
      test_dual_bank();
      test_same_bank();
      test_coalesce();
      test_init_overflow();
      test_drop_saturate();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
